// File: rtl/elevator_dispatch.sv
// elevator_dispatch: LOOK-algorithm floor scheduler.
// Collects hall/car calls into a pending bitmask, issues one target floor at a
// time to the car over a valid/ready handshake, and times the door at each stop.
module elevator_dispatch #(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  input  logic [FLOOR_W-1:0]  i_req_floor,
  input  logic [FLOOR_W-1:0]  i_car_floor,
  input  logic                i_car_arrived,
  input  logic                i_tgt_ready,
  output logic                o_tgt_valid,
  output logic [FLOOR_W-1:0]  o_tgt_floor,
  output logic                o_door_open,
  output logic                o_dir_up,
  output logic                o_busy,
  output logic [N_FLOORS-1:0] o_pending,
  output logic                o_req_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MOVE, S_DOOR} state_t;

  localparam int                 TIMER_W     = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W+1)'(N_FLOORS);

  state_t              state, state_next;
  logic [TIMER_W-1:0]  timer;
  logic                req_ok, req_bad, req_here, req_set;
  logic                arrive_hit, door_restart, door_done, enter_issue, load_timer;
  logic [N_FLOORS-1:0] set_mask, clr_mask;
  logic                up_found, dn_found, sel_dir_up;
  logic [FLOOR_W-1:0]  up_floor, dn_floor, sel_floor;

  // Request and event qualification.
  assign req_bad      = i_req_valid && ({1'b0, i_req_floor} >= FLOOR_LIMIT);
  assign req_ok       = i_req_valid && !req_bad;
  assign req_here     = req_ok && (i_req_floor == i_car_floor);
  assign req_set      = req_ok && !(req_here && (state == S_IDLE || state == S_DOOR));
  assign arrive_hit   = (state == S_MOVE) && i_car_arrived && (i_car_floor == o_tgt_floor);
  assign door_restart = (state == S_DOOR) && req_here;
  assign door_done    = (state == S_DOOR) && (timer == '0) && !door_restart;
  assign enter_issue  = (state_next == S_ISSUE) && (state != S_ISSUE);
  assign load_timer   = (state_next == S_DOOR) && ((state != S_DOOR) || door_restart);

  // Decode the request and the served floor into one-hot set/clear masks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (req_set && (i_req_floor == FLOOR_W'(i))) set_mask[i] = 1'b1;
      if (arrive_hit && (o_tgt_floor == FLOOR_W'(i))) clr_mask[i] = 1'b1;
    end
  end

  // LOOK search: nearest pending floor above and below the car.
  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (o_pending[i] && (FLOOR_W'(i) > i_car_floor)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (o_pending[i] && (FLOOR_W'(i) < i_car_floor)) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  // Pick the target: keep sweeping, reverse only when nothing lies ahead.
  // A lone call at the car's own floor is served in place with direction kept.
  always_comb begin
    sel_floor  = i_car_floor;
    sel_dir_up = o_dir_up;
    if (o_dir_up) begin
      if (up_found)      begin sel_floor = up_floor; sel_dir_up = 1'b1; end
      else if (dn_found) begin sel_floor = dn_floor; sel_dir_up = 1'b0; end
    end else begin
      if (dn_found)      begin sel_floor = dn_floor; sel_dir_up = 1'b0; end
      else if (up_found) begin sel_floor = up_floor; sel_dir_up = 1'b1; end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_here)          state_next = S_DOOR;
               else if (|o_pending)   state_next = S_ISSUE;
      S_ISSUE: if (i_tgt_ready)       state_next = S_MOVE;
      S_MOVE:  if (arrive_hit)        state_next = S_DOOR;
      S_DOOR:  if (door_done)         state_next = (|o_pending) ? S_ISSUE : S_IDLE;
      default:                        state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_tgt_valid = (state == S_ISSUE);
    o_door_open = (state == S_DOOR);
    o_busy      = (state != S_IDLE);
  end

  // Pending mask, target/direction latch, door timer and error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pending   <= '0;
      o_tgt_floor <= '0;
      o_dir_up    <= 1'b1;
      timer       <= '0;
      o_req_err   <= 1'b0;
    end else begin
      // Clear beats set: a call for the floor being served is already satisfied.
      o_pending <= (o_pending | set_mask) & ~clr_mask;
      o_req_err <= req_bad;
      if (enter_issue) begin
        o_tgt_floor <= sel_floor;
        o_dir_up    <= sel_dir_up;
      end
      if (load_timer)                             timer <= TIMER_LOAD;
      else if (state == S_DOOR && timer != '0)    timer <= timer - 1'b1;
    end
  end

endmodule

// File: tb/tb_elevator_dispatch.sv
// tb_elevator_dispatch: directed scenarios for the LOOK elevator dispatcher,
// with a second 6-floor instance for out-of-range request handling.
module tb_elevator_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, car_arrived = 1'b0, tgt_ready = 1'b0;
  logic [2:0] req_floor = '0, car_floor = '0;
  logic       tgt_valid, door_open, dir_up, busy, req_err;
  logic [2:0] tgt_floor;
  logic [7:0] pending;

  logic       req_valid6 = 1'b0;
  logic [2:0] req_floor6 = '0;
  logic       tgt_valid6, door_open6, dir_up6, busy6, req_err6;
  logic [2:0] tgt_floor6;
  logic [5:0] pending6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elevator_dispatch #(.N_FLOORS(8), .FLOOR_W(3), .DOOR_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_floor(req_floor),
    .i_car_floor(car_floor), .i_car_arrived(car_arrived), .i_tgt_ready(tgt_ready),
    .o_tgt_valid(tgt_valid), .o_tgt_floor(tgt_floor), .o_door_open(door_open),
    .o_dir_up(dir_up), .o_busy(busy), .o_pending(pending), .o_req_err(req_err)
  );

  elevator_dispatch #(.N_FLOORS(6), .FLOOR_W(3), .DOOR_CYCLES(4)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid6), .i_req_floor(req_floor6),
    .i_car_floor(3'd0), .i_car_arrived(1'b0), .i_tgt_ready(1'b0),
    .o_tgt_valid(tgt_valid6), .o_tgt_floor(tgt_floor6), .o_door_open(door_open6),
    .o_dir_up(dir_up6), .o_busy(busy6), .o_pending(pending6), .o_req_err(req_err6)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [2:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step();
    req_valid = 1'b0;
  endtask

  task automatic accept();
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;
  endtask

  task automatic arrive(input logic [2:0] f);
    car_floor   = f;
    car_arrived = 1'b1;
    step();
    car_arrived = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tgt_valid) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_vec++;
    if ({tgt_valid, door_open, dir_up, busy, req_err} !== 5'b00100) begin
      n_err++; $display("FAIL reset_flags: got %b expected 00100", {tgt_valid, door_open, dir_up, busy, req_err});
    end
    n_vec++;
    if ({pending, tgt_floor} !== 11'd0) begin
      n_err++; $display("FAIL reset_regs: pending=%h tgt=%0d expected 0/0", pending, tgt_floor);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_trip();
    int  cnt;
    bit  ok;
    car_floor = 3'd0;
    pulse_req(3'd5);
    n_vec++;
    if ({tgt_valid, pending} !== {1'b0, 8'h20}) begin
      n_err++; $display("FAIL latency_1: valid=%b pending=%h expected 0/20", tgt_valid, pending);
    end
    step();
    n_vec++;
    if ({tgt_valid, tgt_floor, dir_up} !== {1'b1, 3'd5, 1'b1}) begin
      n_err++; $display("FAIL first_target: valid=%b tgt=%0d up=%b expected 1/5/1", tgt_valid, tgt_floor, dir_up);
    end
    accept();
    n_vec++;
    if ({tgt_valid, busy} !== 2'b01) begin
      n_err++; $display("FAIL move_state: valid=%b busy=%b expected 0/1", tgt_valid, busy);
    end
    arrive(3'd5);
    cnt = 0;
    while (door_open && cnt < 10) begin cnt++; step(); end
    n_vec++;
    if (cnt !== 4) begin
      n_err++; $display("FAIL door_len: got %0d cycles expected 4", cnt);
    end
    wait_idle(ok);
    n_vec++;
    if ({ok, pending} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL trip_done: idle_ok=%b pending=%h expected 1/00", ok, pending);
    end
  endtask

  task automatic test_look_reverse();
    bit ok;
    car_floor = 3'd3;
    pulse_req(3'd6);
    step();
    accept();
    pulse_req(3'd1);
    pulse_req(3'd7);
    n_vec++;
    if (pending !== 8'hC2) begin
      n_err++; $display("FAIL move_pending: got %h expected c2", pending);
    end
    arrive(3'd6);
    wait_valid(ok);
    n_vec++;
    if ({ok, tgt_floor, dir_up} !== {1'b1, 3'd7, 1'b1}) begin
      n_err++; $display("FAIL sweep_up: ok=%b tgt=%0d up=%b expected 1/7/1", ok, tgt_floor, dir_up);
    end
    accept();
    arrive(3'd7);
    wait_valid(ok);
    n_vec++;
    if ({ok, tgt_floor, dir_up} !== {1'b1, 3'd1, 1'b0}) begin
      n_err++; $display("FAIL reverse: ok=%b tgt=%0d up=%b expected 1/1/0", ok, tgt_floor, dir_up);
    end
    accept();
    arrive(3'd1);
    wait_idle(ok);
  endtask

  task automatic test_door_restart();
    int cnt;
    bit issued;
    bit ok;
    car_floor = 3'd2;
    pulse_req(3'd2);
    n_vec++;
    if ({door_open, tgt_valid, pending} !== {2'b10, 8'h00}) begin
      n_err++; $display("FAIL local_call: door=%b valid=%b pending=%h expected 1/0/00", door_open, tgt_valid, pending);
    end
    step();
    step();
    pulse_req(3'd2);
    cnt = 0;
    issued = 1'b0;
    while (door_open && cnt < 10) begin
      if (tgt_valid) issued = 1'b1;
      cnt++;
      step();
    end
    n_vec++;
    if ({cnt, issued} !== {32'd4, 1'b0}) begin
      n_err++; $display("FAIL door_restart: got %0d cycles issued=%b expected 4/0", cnt, issued);
    end
    wait_idle(ok);
  endtask

  task automatic test_hold_and_clear();
    bit ok;
    bit changed;
    car_floor = 3'd2;
    pulse_req(3'd4);
    step();
    n_vec++;
    if ({tgt_valid, tgt_floor, dir_up} !== {1'b1, 3'd4, 1'b1}) begin
      n_err++; $display("FAIL flip_up: valid=%b tgt=%0d up=%b expected 1/4/1", tgt_valid, tgt_floor, dir_up);
    end
    changed = 1'b0;
    pulse_req(3'd0); if (tgt_floor !== 3'd4 || !tgt_valid) changed = 1'b1;
    pulse_req(3'd6); if (tgt_floor !== 3'd4 || !tgt_valid) changed = 1'b1;
    pulse_req(3'd7); if (tgt_floor !== 3'd4 || !tgt_valid) changed = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (tgt_floor !== 3'd4 || !tgt_valid) changed = 1'b1;
    end
    n_vec++;
    if ({changed, pending} !== {1'b0, 8'hD1}) begin
      n_err++; $display("FAIL hold_stable: changed=%b pending=%h expected 0/d1", changed, pending);
    end
    accept();
    arrive(3'd4);
    wait_valid(ok);
    n_vec++;
    if ({ok, tgt_floor, pending} !== {1'b1, 3'd6, 8'hC1}) begin
      n_err++; $display("FAIL next_up: ok=%b tgt=%0d pending=%h expected 1/6/c1", ok, tgt_floor, pending);
    end
    accept();
    car_floor   = 3'd6;
    car_arrived = 1'b1;
    req_valid   = 1'b1;
    req_floor   = 3'd6;
    step();
    car_arrived = 1'b0;
    req_valid   = 1'b0;
    n_vec++;
    if ({door_open, pending} !== {1'b1, 8'h81}) begin
      n_err++; $display("FAIL clear_wins: door=%b pending=%h expected 1/81", door_open, pending);
    end
  endtask

  task automatic test_req_err();
    req_valid6 = 1'b1;
    req_floor6 = 3'd7;
    step();
    req_valid6 = 1'b0;
    n_vec++;
    if ({req_err6, pending6} !== {1'b1, 6'h00}) begin
      n_err++; $display("FAIL req_err_pulse: err=%b pending=%h expected 1/00", req_err6, pending6);
    end
    req_valid6 = 1'b1;
    req_floor6 = 3'd5;
    step();
    req_valid6 = 1'b0;
    n_vec++;
    if ({req_err6, pending6} !== {1'b0, 6'h20}) begin
      n_err++; $display("FAIL req_top_floor: err=%b pending=%h expected 0/20", req_err6, pending6);
    end
  endtask

  task automatic test_reset_in_move();
    bit ok;
    wait_valid(ok);
    accept();
    arrive(3'd7);
    wait_valid(ok);
    n_vec++;
    if ({ok, tgt_floor, dir_up} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++; $display("FAIL sweep_down: ok=%b tgt=%0d up=%b expected 1/0/0", ok, tgt_floor, dir_up);
    end
    accept();
    n_vec++;
    if ({busy, pending} !== {1'b1, 8'h01}) begin
      n_err++; $display("FAIL pre_reset: busy=%b pending=%h expected 1/01", busy, pending);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({tgt_valid, door_open, busy, dir_up, pending} !== {4'b0001, 8'h00}) begin
      n_err++; $display("FAIL async_reset: valid=%b door=%b busy=%b up=%b pending=%h expected 0/0/0/1/00",
                        tgt_valid, door_open, busy, dir_up, pending);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_req_err();
    test_single_trip();
    test_look_reverse();
    test_door_restart();
    test_hold_and_clear();
    test_reset_in_move();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
